// File: rtl/gshare_resolve_pkg.sv
// gshare_resolve_pkg: shared counter encodings and FSM state type for the gshare predictor
package gshare_resolve_pkg;
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/gshare_resolve_sat.sv
// sat_counter2: next value of a 2-bit saturating direction counter
module sat_counter2
    import gshare_resolve_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next
);
    always_comb next = taken ? (ctr == CTR_ST  ? CTR_ST  : ctr + 2'd1)
                             : (ctr == CTR_SNT ? CTR_SNT : ctr - 2'd1);
endmodule

// File: rtl/gshare_resolve.sv
// gshare_resolve: gshare predictor with fetch lookup, execute resolve/update, init sweep and stats
module gshare_resolve
    import gshare_resolve_pkg::*;
#(
    parameter int HIST_BITS = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic                 lookup_stall,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_index,
    output logic [1:0]           pred_ctr,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 resolve_valid,
    input  logic [HIST_BITS-1:0] resolve_index,
    input  logic [1:0]           resolve_ctr,
    input  logic [HIST_BITS-1:0] resolve_ghr,
    input  logic                 resolve_taken,
    input  logic [31:0]          resolve_target,
    input  logic [31:0]          resolve_pcplus4,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    output logic                 ready,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count
);
    localparam int DEPTH = 1 << HIST_BITS;

    state_t               state;
    logic [HIST_BITS-1:0] ptr, ghr;
    logic [1:0]           pht [DEPTH];
    logic [1:0]           upd;
    logic                 run, res, unused_pc;

    assign run       = state == RUN;
    assign res       = run && resolve_valid;
    assign unused_pc = ^{lookup_pc[31:HIST_BITS+2], lookup_pc[1:0]};

    always_comb begin
        pred_index  = lookup_pc[HIST_BITS+1:2] ^ ghr;
        pred_ctr    = run ? pht[pred_index] : CTR_WNT;
        pred_taken  = pred_ctr[1];
        pred_ghr    = ghr;
        mispredict  = res && (resolve_ctr[1] != resolve_taken);
        redirect_pc = !resolve_valid ? 32'd0 : resolve_taken ? resolve_target : resolve_pcplus4;
    end

    // Update is based on the carried counter, so a stale read in flight is intentional.
    sat_counter2 u_sat (.ctr(resolve_ctr), .taken(resolve_taken), .next(upd));

    always_ff @(posedge clk) begin
        if (!reset && !run)
            pht[ptr] <= CTR_WNT;
        else if (res)
            pht[resolve_index] <= upd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= INIT;
            ptr              <= '0;
            ghr              <= '0;
            ready            <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (!run) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            end
            // Repair wins over the speculative shift of the same cycle.
            if (mispredict)
                ghr <= {resolve_ghr[HIST_BITS-2:0], resolve_taken};
            else if (run && lookup_valid && !lookup_stall)
                ghr <= {ghr[HIST_BITS-2:0], pred_taken};
            if (res)
                branch_count <= branch_count + 1'b1;
            if (mispredict)
                mispredict_count <= mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_gshare_resolve.sv
// tb_gshare_resolve: randomized + directed scoreboard bench against an abstract predictor model
module tb_gshare_resolve;
    localparam int HB = 4;
    localparam int CW = 4;

    logic          clk = 0, reset = 0;
    logic          lookup_valid = 0, lookup_stall = 0;
    logic [31:0]   lookup_pc = 0;
    logic          pred_taken;
    logic [HB-1:0] pred_index, pred_ghr;
    logic [1:0]    pred_ctr;
    logic          resolve_valid = 0, resolve_taken = 0;
    logic [HB-1:0] resolve_index = 0, resolve_ghr = 0;
    logic [1:0]    resolve_ctr = 0;
    logic [31:0]   resolve_target = 0, resolve_pcplus4 = 0;
    logic          mispredict, ready;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] branch_count, mispredict_count;

    gshare_resolve #(.HIST_BITS(HB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_stall(lookup_stall), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_index(pred_index), .pred_ctr(pred_ctr), .pred_ghr(pred_ghr),
        .resolve_valid(resolve_valid), .resolve_index(resolve_index), .resolve_ctr(resolve_ctr),
        .resolve_ghr(resolve_ghr), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pcplus4(resolve_pcplus4), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .ready(ready), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx, ctr, pt, ghr, mp, rdy, bc, mc;
        bit [31:0] rpc;
    } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0;

    // Abstract model: table of ints, history as an int, sweep as a countdown.
    int pht_m[16];
    int ghr_m, bc_m, mc_m, sweep_left;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ready", 32'(ready), e.rdy);
            chk("pred_index", 32'(pred_index), e.idx);
            chk("pred_ctr", 32'(pred_ctr), e.ctr);
            chk("pred_taken", 32'(pred_taken), e.pt);
            chk("pred_ghr", 32'(pred_ghr), e.ghr);
            chk("mispredict", 32'(mispredict), e.mp);
            chk("redirect_pc", redirect_pc, int'(e.rpc));
            chk("branch_count", 32'(branch_count), e.bc);
            chk("mispredict_count", 32'(mispredict_count), e.mc);
        end
    end

    task automatic step(input bit rst, input bit lv, input bit ls, input int pc,
                        input bit rv, input int ri, input int rc, input int rg, input bit rt,
                        input bit [31:0] tgt, input bit [31:0] p4);
        exp_t e;
        bit rdy, res;
        reset = rst; lookup_valid = lv; lookup_stall = ls; lookup_pc = pc;
        resolve_valid = rv; resolve_index = HB'(ri); resolve_ctr = 2'(rc); resolve_ghr = HB'(rg);
        resolve_taken = rt; resolve_target = tgt; resolve_pcplus4 = p4;
        rdy = sweep_left == 0;
        res = rdy && rv;
        e.rdy = rdy;
        e.idx = ((pc >> 2) % 16) ^ ghr_m;
        e.ctr = rdy ? pht_m[e.idx] : 1;
        e.pt = e.ctr >= 2;
        e.ghr = ghr_m;
        e.mp = res && ((rc >= 2) != rt);
        e.rpc = rv ? (rt ? tgt : p4) : 0;
        e.bc = bc_m;
        e.mc = mc_m;
        if (!rst) q.push_back(e);
        @(posedge clk);
        if (rst) begin
            foreach (pht_m[i]) pht_m[i] = 1;
            ghr_m = 0; bc_m = 0; mc_m = 0; sweep_left = 16;
        end else if (!rdy) begin
            sweep_left--;
        end else begin
            if (res) begin
                pht_m[ri] = rt ? (rc == 3 ? 3 : rc + 1) : (rc == 0 ? 0 : rc - 1);
                bc_m = (bc_m + 1) % 16;
                if (e.mp) mc_m = (mc_m + 1) % 16;
            end
            if (e.mp) ghr_m = ((rg << 1) | int'(rt)) % 16;
            else if (lv && !ls) ghr_m = ((ghr_m << 1) | e.pt) % 16;
        end
        #1;
    endtask

    task automatic lookup(input int pc, input bit lv);
        step(0, lv, 0, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int ri, input int rc, input int rg, input bit rt, input bit [31:0] tgt);
        step(0, 0, 0, 0, 1, ri, rc, rg, rt, tgt, 32'h44);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Sweep: any lookups or resolves are inert for 16 cycles.
        for (int i = 0; i < 16; i++)
            step(0, 1, 0, int'($urandom), 1, int'($urandom_range(15)), 3, 5, 0, 32'h200, 32'h204);
        lookup(32'h40, 1);
        resolve(3, 1, 5, 1, 32'h100);
        lookup(32'h20, 0);
        resolve(5, 3, 11, 1, 32'h300);
        resolve(6, 0, 11, 0, 32'h300);
        lookup(32'h38, 0);
        lookup(32'h34, 0);
        // Lookup predicting taken alongside a mispredict: only the repair lands.
        step(0, 1, 0, 32'h20, 1, 7, 0, 2, 1, 32'h500, 32'h504);
        lookup(32'h00, 0);
        resolve(3, 2, 5, 1, 32'h100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) lookup(int'($urandom), 1);
        lookup(32'h0c, 0);
        for (int i = 0; i < 17; i++) resolve(int'($urandom_range(15)), 3, 0, 1, 32'h600);
        for (int i = 0; i < 500; i++) begin
            bit rv;
            rv = $urandom_range(9) < 4;
            step(0, $urandom_range(1), $urandom_range(3) == 0, int'($urandom), rv,
                 int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(15)),
                 $urandom_range(1), $urandom, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
